// File: rtl/vga_console_writer_if.sv
// Character-stream and memory-write signals of the VGA console writer.
// slave: the writer itself. master: the CPU port / arbiter side.
interface vga_console_writer_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ASCII_SIZE = 8
);
    logic                  charValid;
    logic [ASCII_SIZE-1:0] charData;
    logic                  charReady;
    logic                  memWriteEn;
    logic [WORD_SIZE-1:0]  memWriteAdd;
    logic [WORD_SIZE-1:0]  memDataWrite;
    logic                  memWriteGnt;

    modport master (
        output charValid, charData, memWriteGnt,
        input  charReady, memWriteEn, memWriteAdd, memDataWrite
    );

    modport slave (
        input  charValid, charData, memWriteGnt,
        output charReady, memWriteEn, memWriteAdd, memDataWrite
    );
endinterface

// File: rtl/vga_console_writer.sv
// Writes a character stream into the VGA text region of main memory as packed
// words, tracking a text cursor. Handles printable characters, newline (pad the
// rest of the row with spaces) and form feed (clear the whole screen).
module vga_console_writer #(
    parameter int unsigned WORD_SIZE      = 32,
    parameter int unsigned ASCII_SIZE     = 8,
    parameter int unsigned CHARS_HORZ     = 80,
    parameter int unsigned CHARS_VERT     = 60,
    parameter int unsigned VGA_MEM_OFFSET = 0,
    localparam int unsigned COL_W = $clog2(CHARS_HORZ),
    localparam int unsigned ROW_W = $clog2(CHARS_VERT)
) (
    input  logic                    clk,
    input  logic                    reset,
    vga_console_writer_if.slave     bus,
    output logic [COL_W-1:0]        cursorCol,
    output logic [ROW_W-1:0]        cursorRow,
    output logic                    busy
);
    localparam int unsigned CPW           = WORD_SIZE / ASCII_SIZE;
    localparam int unsigned WORDS_PER_ROW = CHARS_HORZ / CPW;
    localparam int unsigned TOTAL_WORDS   = CHARS_HORZ * CHARS_VERT / CPW;

    localparam logic [ASCII_SIZE-1:0] CH_SPACE = ASCII_SIZE'(8'h20);
    localparam logic [ASCII_SIZE-1:0] CH_TILDE = ASCII_SIZE'(8'h7E);
    localparam logic [ASCII_SIZE-1:0] CH_LF    = ASCII_SIZE'(8'h0A);
    localparam logic [ASCII_SIZE-1:0] CH_FF    = ASCII_SIZE'(8'h0C);
    localparam logic [WORD_SIZE-1:0]  SPACES   = {CPW{CH_SPACE}};
    localparam logic [WORD_SIZE-1:0]  BASE     = WORD_SIZE'(VGA_MEM_OFFSET);

    typedef enum logic [1:0] {StAccept, StWrite, StPad, StClear} state_e;

    state_e                 state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [WORD_SIZE-1:0]   word_buf_q, word_buf_d;
    logic [WORD_SIZE-1:0]   idx_q, idx_d;
    logic                   we_q, we_d;
    logic [WORD_SIZE-1:0]   add_q, add_d;
    logic [WORD_SIZE-1:0]   data_q, data_d;

    logic [WORD_SIZE-1:0]   lin_pos, slot, char_addr, row_base, pad_start;
    logic [WORD_SIZE-1:0]   char_word;
    logic [ROW_W-1:0]       row_next;
    logic                   printable;

    // Cursor-derived addressing and the word with the incoming character inserted.
    always_comb begin
        lin_pos   = WORD_SIZE'(row_q) * WORD_SIZE'(CHARS_HORZ) + WORD_SIZE'(col_q);
        slot      = WORD_SIZE'(col_q) % WORD_SIZE'(CPW);
        char_addr = BASE + lin_pos / WORD_SIZE'(CPW);
        row_base  = BASE + WORD_SIZE'(row_q) * WORD_SIZE'(WORDS_PER_ROW);
        pad_start = (WORD_SIZE'(col_q) + WORD_SIZE'(CPW - 1)) / WORD_SIZE'(CPW);
        row_next  = (row_q == ROW_W'(CHARS_VERT - 1)) ? '0 : row_q + ROW_W'(1);
        printable = (bus.charData >= CH_SPACE) && (bus.charData <= CH_TILDE);
        // A fresh word starts as all spaces; slot 0 is the most significant byte.
        char_word = (slot == '0) ? SPACES : word_buf_q;
        for (int i = 0; i < int'(CPW); i++) begin
            if (slot == WORD_SIZE'(i)) begin
                char_word[WORD_SIZE-1-i*ASCII_SIZE -: ASCII_SIZE] = bus.charData;
            end
        end
    end

    // Next-state logic: character decode, write handshake, row pad and screen clear.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        word_buf_d = word_buf_q;
        idx_d      = idx_q;
        we_d       = we_q;
        add_d      = add_q;
        data_d     = data_q;
        unique case (state_q)
            StAccept: begin
                if (bus.charValid) begin
                    if (printable) begin
                        word_buf_d = char_word;
                        data_d     = char_word;
                        add_d      = char_addr;
                        we_d       = 1'b1;
                        state_d    = StWrite;
                    end else if (bus.charData == CH_LF) begin
                        if (pad_start == WORD_SIZE'(WORDS_PER_ROW)) begin
                            // Cursor already in the last word of the row: nothing to pad.
                            col_d = '0;
                            row_d = row_next;
                        end else begin
                            idx_d   = pad_start;
                            add_d   = row_base + pad_start;
                            data_d  = SPACES;
                            we_d    = 1'b1;
                            state_d = StPad;
                        end
                    end else if (bus.charData == CH_FF) begin
                        idx_d   = '0;
                        add_d   = BASE;
                        data_d  = SPACES;
                        we_d    = 1'b1;
                        state_d = StClear;
                    end
                end
            end
            StWrite: begin
                if (bus.memWriteGnt) begin
                    we_d    = 1'b0;
                    state_d = StAccept;
                    if (col_q == COL_W'(CHARS_HORZ - 1)) begin
                        col_d = '0;
                        row_d = row_next;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            StPad: begin
                if (bus.memWriteGnt) begin
                    if (idx_q == WORD_SIZE'(WORDS_PER_ROW - 1)) begin
                        we_d    = 1'b0;
                        col_d   = '0;
                        row_d   = row_next;
                        state_d = StAccept;
                    end else begin
                        idx_d = idx_q + WORD_SIZE'(1);
                        add_d = add_q + WORD_SIZE'(1);
                    end
                end
            end
            StClear: begin
                if (bus.memWriteGnt) begin
                    if (idx_q == WORD_SIZE'(TOTAL_WORDS - 1)) begin
                        we_d    = 1'b0;
                        col_d   = '0;
                        row_d   = '0;
                        state_d = StAccept;
                    end else begin
                        idx_d = idx_q + WORD_SIZE'(1);
                        add_d = add_q + WORD_SIZE'(1);
                    end
                end
            end
            default: state_d = StAccept;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight write immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StAccept;
            col_q      <= '0;
            row_q      <= '0;
            word_buf_q <= '0;
            idx_q      <= '0;
            we_q       <= 1'b0;
            add_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            word_buf_q <= word_buf_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            add_q      <= add_d;
            data_q     <= data_d;
        end
    end

    assign bus.charReady    = (state_q == StAccept);
    assign busy             = (state_q != StAccept);
    assign bus.memWriteEn   = we_q;
    assign bus.memWriteAdd  = add_q;
    assign bus.memDataWrite = data_q;
    assign cursorCol        = col_q;
    assign cursorRow        = row_q;
endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer: character writes, newline padding with
// grant stalls, cursor wrap, screen clear and reset mid-sequence.
module tb_vga_console_writer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] cursorCol;
    logic [5:0] cursorRow;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    logic [31:0] aq[$];
    logic [31:0] dq[$];

    vga_console_writer_if #(.WORD_SIZE(32), .ASCII_SIZE(8)) bus ();

    vga_console_writer #(
        .WORD_SIZE(32), .ASCII_SIZE(8), .CHARS_HORZ(80), .CHARS_VERT(60),
        .VGA_MEM_OFFSET(32'h1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .cursorCol(cursorCol),
        .cursorRow(cursorRow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Log every granted write.
    always @(posedge clk) begin
        if (!reset && bus.memWriteEn && bus.memWriteGnt) begin
            aq.push_back(bus.memWriteAdd);
            dq.push_back(bus.memDataWrite);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a character and hold it until the handshake edge; returns 1 time unit after it.
    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge clk);
        bus.charValid = 1'b1;
        bus.charData  = c;
        while (!bus.charReady && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.charValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic clear_log();
        aq.delete();
        dq.delete();
    endtask

    initial begin
        int bad;
        int cyc;
        bus.charValid   = 1'b0;
        bus.charData    = 8'h00;
        bus.memWriteGnt = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.charReady), 32'd1);
        check("rst_we", 32'(bus.memWriteEn), 32'd0);
        check("rst_add", bus.memWriteAdd, 32'd0);
        check("rst_data", bus.memDataWrite, 32'd0);
        check("rst_col", 32'(cursorCol), 32'd0);
        check("rst_row", 32'(cursorRow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 'H' then 'i' with grant held high.
        clear_log();
        send(8'h48);
        check("h_we_latency", 32'(bus.memWriteEn), 32'd1);
        check("h_add", bus.memWriteAdd, 32'h1000);
        check("h_data", bus.memDataWrite, 32'h48202020);
        send(8'h69);
        wait_idle();
        check("hi_count", 32'(aq.size()), 32'd2);
        check("hi_add1", aq[1], 32'h1000);
        check("hi_data1", dq[1], 32'h48692020);
        check("hi_col", 32'(cursorCol), 32'd2);
        check("hi_row", 32'(cursorRow), 32'd0);

        // Newline at col 2, grant low for the first three edges of the first PAD write.
        clear_log();
        bus.memWriteGnt = 1'b0;
        send(8'h0A);
        for (int i = 0; i < 3; i++) begin
            check("stall_we", 32'(bus.memWriteEn), 32'd1);
            check("stall_add", bus.memWriteAdd, 32'h1001);
            check("stall_data", bus.memDataWrite, 32'h20202020);
            @(posedge clk);
            #1;
        end
        check("stall_nowrites", 32'(aq.size()), 32'd0);
        bus.memWriteGnt = 1'b1;
        wait_idle();
        check("nl2_count", 32'(aq.size()), 32'd19);
        bad = 0;
        foreach (aq[i]) if (aq[i] !== 32'h1001 + 32'(i) || dq[i] !== 32'h20202020) bad++;
        check("nl2_seq", 32'(bad), 32'd0);
        check("nl2_col", 32'(cursorCol), 32'd0);
        check("nl2_row", 32'(cursorRow), 32'd1);

        // Newline at col 0 pads the whole row.
        clear_log();
        send(8'h0A);
        wait_idle();
        check("nl0_count", 32'(aq.size()), 32'd20);
        bad = 0;
        foreach (aq[i]) if (aq[i] !== 32'h1014 + 32'(i) || dq[i] !== 32'h20202020) bad++;
        check("nl0_seq", 32'(bad), 32'd0);
        check("nl0_row", 32'(cursorRow), 32'd2);

        // Move to (79, 59) and write 'A' in the last cell.
        for (int i = 0; i < 57; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h20);
        wait_idle();
        check("pre_a_col", 32'(cursorCol), 32'd79);
        check("pre_a_row", 32'(cursorRow), 32'd59);
        clear_log();
        send(8'h41);
        wait_idle();
        check("a_count", 32'(aq.size()), 32'd1);
        check("a_add", aq[0], 32'h14AF);
        check("a_data", dq[0], 32'h20202041);
        check("a_wrap_col", 32'(cursorCol), 32'd0);
        check("a_wrap_row", 32'(cursorRow), 32'd0);

        // Non-printable control code is consumed silently.
        send(8'h51);
        wait_idle();
        clear_log();
        send(8'h07);
        repeat (3) @(negedge clk);
        check("bel_nowrite", 32'(aq.size()), 32'd0);
        check("bel_col", 32'(cursorCol), 32'd1);
        check("bel_busy", 32'(busy), 32'd0);

        // Form feed clears the screen at one write per cycle.
        clear_log();
        send(8'h0C);
        bad = 0;
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 5000) begin
            if (bus.charReady) bad++;
            @(negedge clk);
            cyc++;
        end
        check("ff_cycles", 32'(cyc), 32'd1200);
        check("ff_ready_low", 32'(bad), 32'd0);
        check("ff_count", 32'(aq.size()), 32'd1200);
        bad = 0;
        foreach (aq[i]) if (aq[i] !== 32'h1000 + 32'(i) || dq[i] !== 32'h20202020) bad++;
        check("ff_seq", 32'(bad), 32'd0);
        check("ff_col", 32'(cursorCol), 32'd0);
        check("ff_row", 32'(cursorRow), 32'd0);

        // Reset in the middle of a PAD sequence.
        send(8'h51);
        wait_idle();
        clear_log();
        send(8'h0A);
        cyc = 0;
        while (aq.size() < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("pad5_count", 32'(aq.size()), 32'd5);
        check("pad5_we", 32'(bus.memWriteEn), 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_we", 32'(bus.memWriteEn), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_count", 32'(aq.size()), 32'd5);
        check("rst_mid_ready", 32'(bus.charReady), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_col", 32'(cursorCol), 32'd0);
        check("rst_mid_row", 32'(cursorRow), 32'd0);
        clear_log();
        send(8'h48);
        wait_idle();
        check("post_rst_add", aq.size() > 0 ? aq[0] : 32'hFFFF_FFFF, 32'h1000);
        check("post_rst_data", dq.size() > 0 ? dq[0] : 32'hFFFF_FFFF, 32'h48202020);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
